// File: rtl/can_field_tracker_if.sv
// Bit-level interface of the CAN field tracker: sample-point inputs and field/flag outputs.
// F_EOF exists only when CAN_FIELD_EOF_FLAG_EN is defined.
interface can_field_tracker_if;
  logic       SP;
  logic       RX;
  logic       stuff_bit;
  logic       err_abort;
  logic       F_CRC_D;
  logic       F_ACK_D;
  logic [4:0] field;
  logic       frame_active;
  logic       frame_done;
  logic [3:0] dlc_out;
  logic       ide_out;
  logic       rtr_out;
`ifdef CAN_FIELD_EOF_FLAG_EN
  logic       F_EOF;
`endif

  modport master (
`ifdef CAN_FIELD_EOF_FLAG_EN
    input  F_EOF,
`endif
    output SP, RX, stuff_bit, err_abort,
    input  F_CRC_D, F_ACK_D, field, frame_active, frame_done, dlc_out, ide_out, rtr_out
  );

  modport slave (
`ifdef CAN_FIELD_EOF_FLAG_EN
    output F_EOF,
`endif
    input  SP, RX, stuff_bit, err_abort,
    output F_CRC_D, F_ACK_D, field, frame_active, frame_done, dlc_out, ide_out, rtr_out
  );
endinterface

// File: rtl/can_field_tracker.sv
// Follows destuffed CAN 2.0A/B frames at the sample point and drives active-low delimiter flags.
// Optional active-low EOF flag output enabled by CAN_FIELD_EOF_FLAG_EN.
module can_field_tracker #(
  parameter int INTEG_BITS = 11,
  parameter int EOF_BITS   = 7,
  parameter int IFS_BITS   = 3
) (
  input logic           clock,
  input logic           reset,
  can_field_tracker_if.slave bus
);

  typedef enum logic [4:0] {
    S_INTEG, S_IDLE, S_SOF, S_ID_A, S_RTR_SRR, S_IDE, S_ID_B, S_RTR_B, S_R1, S_R0,
    S_DLC, S_DATA, S_CRC, S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF, S_IFS
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [3:0] dlc_q, dlc_d;
  logic       srr_q, srr_d;
  logic       ide_q, ide_d;
  logic       rtr_q, rtr_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       fcrc_q, fcrc_d;
  logic       fack_q, fack_d;
  logic       feof_q, feof_d;
  logic [6:0] cnt_inc;
  logic [3:0] dlc_next;
  logic       hold;
  logic       sof;

  // Remote frames carry no data; DLC 9..15 still means 8 bytes.
  function automatic logic [6:0] data_bits(input logic [3:0] dlc, input logic rtr);
    if (rtr)         return '0;
    else if (dlc[3]) return 7'd64;
    else             return {1'b0, dlc[2:0], 3'b000};
  endfunction

  assign cnt_inc  = cnt_q + 7'd1;
  assign dlc_next = {dlc_q[2:0], bus.RX};
  assign hold     = bus.stuff_bit && (state_q inside {[S_SOF:S_CRC]});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dlc_d    = dlc_q;
    srr_d    = srr_q;
    ide_d    = ide_q;
    rtr_d    = rtr_q;
    active_d = active_q;
    done_d   = 1'b0;
    sof      = 1'b0;
    if (bus.err_abort) begin
      state_d  = S_INTEG;
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (bus.SP && !hold) begin
      case (state_q)
        S_INTEG: begin
          if (!bus.RX) cnt_d = '0;
          else if (cnt_inc == 7'(INTEG_BITS)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        end
        S_IDLE:    sof = !bus.RX;
        S_SOF:     state_d = S_ID_A;
        S_ID_A: begin
          cnt_d = cnt_inc;
          if (cnt_inc == 7'd11) begin
            state_d = S_RTR_SRR;
            cnt_d   = '0;
          end
        end
        S_RTR_SRR: begin
          srr_d   = bus.RX;
          state_d = S_IDE;
        end
        S_IDE: begin
          ide_d = bus.RX;
          if (bus.RX) state_d = S_ID_B;
          else begin
            rtr_d   = srr_q;
            state_d = S_R0;
          end
        end
        S_ID_B: begin
          cnt_d = cnt_inc;
          if (cnt_inc == 7'd18) begin
            state_d = S_RTR_B;
            cnt_d   = '0;
          end
        end
        S_RTR_B: begin
          rtr_d   = bus.RX;
          state_d = S_R1;
        end
        S_R1:      state_d = S_R0;
        S_R0:      state_d = S_DLC;
        S_DLC: begin
          dlc_d = dlc_next;
          cnt_d = cnt_inc;
          if (cnt_inc == 7'd4) begin
            cnt_d   = '0;
            state_d = (data_bits(dlc_next, rtr_q) == '0) ? S_CRC : S_DATA;
          end
        end
        S_DATA: begin
          cnt_d = cnt_inc;
          if (cnt_inc == data_bits(dlc_q, rtr_q)) begin
            state_d = S_CRC;
            cnt_d   = '0;
          end
        end
        S_CRC: begin
          cnt_d = cnt_inc;
          if (cnt_inc == 7'd15) begin
            state_d = S_CRC_DELIM;
            cnt_d   = '0;
          end
        end
        S_CRC_DELIM: state_d = S_ACK_SLOT;
        S_ACK_SLOT:  state_d = S_ACK_DELIM;
        S_ACK_DELIM: begin
          state_d = S_EOF;
          cnt_d   = '0;
        end
        S_EOF: begin
          if (!bus.RX) begin
            state_d  = S_INTEG;
            cnt_d    = '0;
            active_d = 1'b0;
          end else if (cnt_inc == 7'(EOF_BITS)) begin
            state_d  = S_IFS;
            cnt_d    = '0;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else cnt_d = cnt_inc;
        end
        S_IFS: begin
          // A dominant last intermission bit is a legal SOF; earlier ones force re-integration.
          if (cnt_inc == 7'(IFS_BITS)) begin
            if (!bus.RX) sof = 1'b1;
            else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else if (!bus.RX) begin
            state_d = S_INTEG;
            cnt_d   = '0;
          end else cnt_d = cnt_inc;
        end
        default: begin
          state_d = S_INTEG;
          cnt_d   = '0;
        end
      endcase
      if (sof) begin
        state_d  = S_ID_A;
        cnt_d    = '0;
        active_d = 1'b1;
        dlc_d    = '0;
        ide_d    = 1'b0;
        rtr_d    = 1'b0;
      end
    end
    fcrc_d = (state_d != S_CRC_DELIM);
    fack_d = (state_d != S_ACK_DELIM);
    feof_d = (state_d != S_EOF);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_INTEG;
      cnt_q    <= '0;
      dlc_q    <= '0;
      srr_q    <= 1'b0;
      ide_q    <= 1'b0;
      rtr_q    <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      fcrc_q   <= 1'b1;
      fack_q   <= 1'b1;
      feof_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dlc_q    <= dlc_d;
      srr_q    <= srr_d;
      ide_q    <= ide_d;
      rtr_q    <= rtr_d;
      active_q <= active_d;
      done_q   <= done_d;
      fcrc_q   <= fcrc_d;
      fack_q   <= fack_d;
      feof_q   <= feof_d;
    end
  end

  assign bus.field        = state_q;
  assign bus.F_CRC_D      = fcrc_q;
  assign bus.F_ACK_D      = fack_q;
  assign bus.frame_active = active_q;
  assign bus.frame_done   = done_q;
  assign bus.dlc_out      = dlc_q;
  assign bus.ide_out      = ide_q;
  assign bus.rtr_out      = rtr_q;
`ifdef CAN_FIELD_EOF_FLAG_EN
  assign bus.F_EOF        = feof_q;
`else
  logic unused_feof;
  assign unused_feof = feof_q;
`endif

endmodule

// File: tb/tb_can_field_tracker.sv
// Randomized bench for can_field_tracker: frames are built as labelled bit streams and the
// expected field/flags after each sample point follow from the label of the next bit.
module tb_can_field_tracker;
  localparam int L_INTEG = 0,  L_IDLE = 1,  L_ID_A = 3,  L_RTR_SRR = 4, L_IDE = 5, L_ID_B = 6;
  localparam int L_RTR_B = 7,  L_R1 = 8,    L_R0 = 9,    L_DLC = 10,    L_DATA = 11;
  localparam int L_CRC = 12,   L_CRCD = 13, L_ACKS = 14, L_ACKD = 15,   L_EOF = 16, L_IFS = 17;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  can_field_tracker_if ifc();

  can_field_tracker #(.INTEG_BITS(11), .EOF_BITS(7), .IFS_BITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Stream entry i: bit value, stuff flag, label = state waiting for that bit, frame_done expected.
  int lab_q[$];
  bit bit_q[$];
  bit stf_q[$];
  bit dn_q[$];
  int end_lab;
  int crc_cnt, crc_pos, ack_cnt, ack_pos, data_cnt, done_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int lab, input bit b, input bit s);
    lab_q.push_back(lab);
    bit_q.push_back(b);
    stf_q.push_back(s);
    dn_q.push_back(1'b0);
  endtask

  // mode: 0 plain, 1 random stuff bits, 2 random (ignored) stuff flag on real bits,
  // 3 stuff bits inserted at three fixed positions.
  task automatic add(input int lab, input logic [63:0] v, input int n, input int mode);
    for (int k = n - 1; k >= 0; k--) begin
      if ((mode == 1 && $urandom_range(0, 11) == 0) ||
          (mode == 3 && (k == n - 5 || k == n - 20 || k == n - 40)))
        push(lab, 1'($urandom_range(0, 1)), 1'b1);
      push(lab, v[k], (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
  endtask

  task automatic clear_stream();
    lab_q.delete();
    bit_q.delete();
    stf_q.delete();
    dn_q.delete();
  endtask

  task automatic build_frame(input int start_lab, input bit ide, input bit rtr,
                             input logic [28:0] id, input logic [3:0] dlc,
                             input logic [63:0] data, input int smode, input int eof_ok);
    int m, ig, nbytes;
    m  = (smode == 1) ? 1 : 0;
    ig = (smode == 0) ? 0 : 2;
    add(start_lab, 64'd0, 1, 0);
    if (!ide) begin
      add(L_ID_A, 64'(id[10:0]), 11, m);
      add(L_RTR_SRR, 64'(rtr), 1, m);
      add(L_IDE, 64'd0, 1, m);
      add(L_R0, 64'($urandom_range(0, 1)), 1, m);
    end else begin
      add(L_ID_A, 64'(id[28:18]), 11, m);
      add(L_RTR_SRR, 64'd1, 1, m);
      add(L_IDE, 64'd1, 1, m);
      add(L_ID_B, 64'(id[17:0]), 18, m);
      add(L_RTR_B, 64'(rtr), 1, m);
      add(L_R1, 64'($urandom_range(0, 1)), 1, m);
      add(L_R0, 64'($urandom_range(0, 1)), 1, m);
    end
    add(L_DLC, 64'(dlc), 4, m);
    nbytes = rtr ? 0 : ((int'(dlc) > 8) ? 8 : int'(dlc));
    if (nbytes > 0) add(L_DATA, data, nbytes * 8, (smode == 3) ? 3 : m);
    add(L_CRC, 64'($urandom), 15, m);
    add(L_CRCD, 64'd1, 1, ig);
    add(L_ACKS, 64'($urandom_range(0, 1)), 1, ig);
    add(L_ACKD, 64'd1, 1, ig);
    if (eof_ok >= 7) begin
      add(L_EOF, 64'h7f, 7, ig);
      dn_q[dn_q.size() - 1] = 1'b1;
    end else begin
      add(L_EOF, '1, eof_ok, ig);
      add(L_EOF, 64'd0, 1, ig);
    end
  endtask

  task automatic idle_clk();
    ifc.SP        = 1'b0;
    ifc.RX        = 1'($urandom_range(0, 1));
    ifc.stuff_bit = 1'($urandom_range(0, 1));
    @(posedge clock);
    #1;
  endtask

  task automatic play(input int limit);
    int nl;
    crc_cnt = 0; crc_pos = -1; ack_cnt = 0; ack_pos = -1; data_cnt = 0; done_cnt = 0;
    for (int i = 0; i < limit; i++) begin
      repeat ($urandom_range(0, 2)) idle_clk();
      if (ifc.F_CRC_D == 1'b0) begin crc_cnt++; crc_pos = i; end
      if (ifc.F_ACK_D == 1'b0) begin ack_cnt++; ack_pos = i; end
      if (int'(ifc.field) == L_DATA) data_cnt++;
      ifc.SP        = 1'b1;
      ifc.RX        = bit_q[i];
      ifc.stuff_bit = stf_q[i];
      @(posedge clock);
      #1;
      ifc.SP = 1'b0;
      nl = (i + 1 < lab_q.size()) ? lab_q[i + 1] : end_lab;
      chk("field", 32'(ifc.field), 32'(nl));
      chk("F_CRC_D", 32'(ifc.F_CRC_D), 32'(nl != L_CRCD));
      chk("F_ACK_D", 32'(ifc.F_ACK_D), 32'(nl != L_ACKD));
      chk("frame_active", 32'(ifc.frame_active), 32'(nl >= L_ID_A && nl <= L_EOF));
      chk("frame_done", 32'(ifc.frame_done), 32'(dn_q[i]));
`ifdef CAN_FIELD_EOF_FLAG_EN
      chk("F_EOF", 32'(ifc.F_EOF), 32'(nl != L_EOF));
`endif
      if (ifc.frame_done) done_cnt++;
      idle_clk();
      chk("done_pulse_width", 32'(ifc.frame_done), 32'd0);
    end
  endtask

  task automatic run_seg(input int e);
    end_lab = e;
    play(lab_q.size());
  endtask

  task automatic frame_checks(input bit ide, input bit rtr, input logic [3:0] dlc, input int ndone);
    chk("dlc_out", 32'(ifc.dlc_out), 32'(dlc));
    chk("ide_out", 32'(ifc.ide_out), 32'(ide));
    chk("rtr_out", 32'(ifc.rtr_out), 32'(rtr));
    chk("done_count", 32'(done_cnt), 32'(ndone));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_field"}, 32'(ifc.field), 32'(L_INTEG));
    chk({tag, "_F_CRC_D"}, 32'(ifc.F_CRC_D), 32'd1);
    chk({tag, "_F_ACK_D"}, 32'(ifc.F_ACK_D), 32'd1);
    chk({tag, "_active"}, 32'(ifc.frame_active), 32'd0);
    chk({tag, "_done"}, 32'(ifc.frame_done), 32'd0);
    chk({tag, "_dlc"}, 32'(ifc.dlc_out), 32'd0);
    chk({tag, "_ide"}, 32'(ifc.ide_out), 32'd0);
    chk({tag, "_rtr"}, 32'(ifc.rtr_out), 32'd0);
`ifdef CAN_FIELD_EOF_FLAG_EN
    chk({tag, "_F_EOF"}, 32'(ifc.F_EOF), 32'd1);
`endif
  endtask

  task automatic integrate();
    clear_stream();
    add(L_INTEG, '1, 11, 0);
    run_seg(L_IDLE);
  endtask

  function automatic int first_idx(input int lab);
    for (int i = 0; i < lab_q.size(); i++) if (lab_q[i] == lab) return i;
    return 0;
  endfunction

  initial begin
    int start, tr, eofk, e, lim;
    bit ide, rtr;
    logic [3:0] dlc;
    ifc.SP = 1'b0; ifc.RX = 1'b1; ifc.stuff_bit = 1'b0; ifc.err_abort = 1'b0;
    #22;
    reset_checks("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    // Integration: 10 recessive is not enough, dominant restarts the count.
    clear_stream();
    add(L_INTEG, '1, 10, 0);
    add(L_INTEG, 64'd0, 1, 0);
    add(L_INTEG, '1, 11, 0);
    run_seg(L_IDLE);

    // Standard data frame ID 0x123, DLC 2.
    clear_stream();
    build_frame(L_IDLE, 1'b0, 1'b0, 29'h123, 4'd2, 64'hA55A, 0, 7);
    add(L_IFS, '1, 3, 0);
    run_seg(L_IDLE);
    frame_checks(1'b0, 1'b0, 4'd2, 1);
    chk("std_crc_delim_count", 32'(crc_cnt), 32'd1);
    chk("std_crc_delim_pos", 32'(crc_pos), 32'(19 + 2 * 8 + 15));
    chk("std_ack_delim_count", 32'(ack_cnt), 32'd1);
    chk("std_ack_delim_pos", 32'(ack_pos), 32'(19 + 2 * 8 + 15 + 2));
    chk("std_data_bits", 32'(data_cnt), 32'd16);

    // Extended remote frame, DLC 15: no data field.
    clear_stream();
    build_frame(L_IDLE, 1'b1, 1'b1, 29'($urandom), 4'd15, 64'd0, 0, 7);
    add(L_IFS, '1, 3, 0);
    run_seg(L_IDLE);
    frame_checks(1'b1, 1'b1, 4'd15, 1);
    chk("ext_rtr_data_bits", 32'(data_cnt), 32'd0);
    chk("ext_rtr_crc_delim_pos", 32'(crc_pos), 32'(39 + 15));

    // DLC 12 with three stuff bits inside DATA; ends with two recessive IFS bits.
    clear_stream();
    build_frame(L_IDLE, 1'b0, 1'b0, 29'($urandom), 4'd12, {$urandom, $urandom}, 3, 7);
    add(L_IFS, '1, 2, 0);
    run_seg(L_IFS);
    frame_checks(1'b0, 1'b0, 4'd12, 1);
    chk("dlc12_data_sps", 32'(data_cnt), 32'(64 + 3));
    chk("dlc12_crc_delim_pos", 32'(crc_pos), 32'(19 + 64 + 15 + 3));

    // SOF on the last IFS bit, then a dominant first IFS bit.
    clear_stream();
    build_frame(L_IFS, 1'b0, 1'b0, 29'($urandom), 4'd1, 64'($urandom), 0, 7);
    add(L_IFS, 64'd0, 1, 0);
    add(L_INTEG, '1, 11, 0);
    run_seg(L_IDLE);
    frame_checks(1'b0, 1'b0, 4'd1, 1);

    // Dominant bit in EOF: no frame_done.
    clear_stream();
    build_frame(L_IDLE, 1'b1, 1'b0, 29'($urandom), 4'd3, 64'($urandom), 1, 4);
    add(L_INTEG, '1, 11, 0);
    run_seg(L_IDLE);
    frame_checks(1'b1, 1'b0, 4'd3, 0);

    // Random frames with random stuff bits and random endings.
    start = L_IDLE;
    for (int r = 0; r < 25; r++) begin
      clear_stream();
      if (start == L_IDLE) add(L_IDLE, '1, $urandom_range(0, 3), 0);
      ide  = 1'($urandom_range(0, 1));
      rtr  = ($urandom_range(0, 3) == 0);
      dlc  = 4'($urandom_range(0, 15));
      tr   = $urandom_range(0, 3);
      if (r == 24 && tr == 1) tr = 0;
      eofk = (tr == 3) ? $urandom_range(0, 6) : 7;
      build_frame(start, ide, rtr, 29'($urandom), dlc, {$urandom, $urandom}, 1, eofk);
      case (tr)
        0: begin add(L_IFS, '1, 3, 2); e = L_IDLE; end
        1: begin add(L_IFS, '1, 2, 2); e = L_IFS; end
        2: begin add(L_IFS, 64'd0, 1, 2); add(L_INTEG, '1, 11, 0); e = L_IDLE; end
        default: begin add(L_INTEG, '1, 11, 0); e = L_IDLE; end
      endcase
      run_seg(e);
      frame_checks(ide, rtr, dlc, (tr == 3) ? 0 : 1);
      start = e;
    end

    // err_abort mid-DATA on a clock without SP.
    clear_stream();
    build_frame(L_IDLE, 1'b0, 1'b0, 29'($urandom), 4'd8, {$urandom, $urandom}, 0, 7);
    lim = first_idx(L_DATA) + 10;
    end_lab = L_IDLE;
    play(lim);
    ifc.SP = 1'b0;
    ifc.err_abort = 1'b1;
    @(posedge clock); #1;
    ifc.err_abort = 1'b0;
    chk("abort_field", 32'(ifc.field), 32'(L_INTEG));
    chk("abort_active", 32'(ifc.frame_active), 32'd0);
    chk("abort_F_CRC_D", 32'(ifc.F_CRC_D), 32'd1);
    chk("abort_F_ACK_D", 32'(ifc.F_ACK_D), 32'd1);
    chk("abort_done", 32'(ifc.frame_done), 32'd0);
    chk("abort_done_count", 32'(done_cnt), 32'd0);
    integrate();

    // err_abort wins over a simultaneous dominant SP in IDLE.
    ifc.SP = 1'b1; ifc.RX = 1'b0; ifc.stuff_bit = 1'b0; ifc.err_abort = 1'b1;
    @(posedge clock); #1;
    ifc.SP = 1'b0; ifc.err_abort = 1'b0;
    chk("abort_prio_field", 32'(ifc.field), 32'(L_INTEG));
    chk("abort_prio_active", 32'(ifc.frame_active), 32'd0);
    integrate();

    // Reset asserted during CRC.
    clear_stream();
    build_frame(L_IDLE, 1'b1, 1'b0, 29'($urandom), 4'd5, {$urandom, $urandom}, 0, 7);
    lim = first_idx(L_CRC) + 5;
    end_lab = L_IDLE;
    play(lim);
    #2;
    reset = 1'b0;
    #1;
    reset_checks("midreset");
    @(posedge clock); #1;
    reset = 1'b1;
    integrate();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
